logs_column_buffer: RTL and testbench
=====================================

# logs_column_buffer

Downstream consumer of the logistic-map iterator. Takes each new `x` (qualified by the iterator's `next_ready` pulse), discards a programmable number of transient iterates, then marks the bins visited by the next `KEEP` iterates in a one-bit-per-bin bitmap. The result is one column of a bifurcation diagram. The bitmap is double-buffered: the display side reads a finished column while the next one is collected.

## Interface
- `FRAC`, 8: fraction bits of `x` (0.FRAC fixed-point). Must match the iterator.
- `BINS_LOG2`, 6: log2 of bin count. Bin index = `x[FRAC-1 -: BINS_LOG2]`. Requires `BINS_LOG2 <= FRAC`.
- `SKIP`, 32: transient iterates discarded per column. Must be ≥ 1.
- `KEEP`, 32: iterates recorded per column. Must be ≥ 1.

- `clk`, in, 1: clock.
- `reset`, in, 1: reset. Asynchronous, active-high.
- `x`, in, FRAC: iterate value from the iterator.
- `next_ready`, in, 1: one-cycle pulse; `x` is valid in that cycle.
- `start`, in, 1: pulse that begins collection of a new column.
- `swap`, in, 1: pulse that exchanges banks once the column is complete.
- `rd_addr`, in, BINS_LOG2: bin index to read from the read bank.
- `rd_bit`, out, 1: registered bitmap bit of the read bank at `rd_addr`.
- `busy`, out, 1: high in states SKIP and COLLECT.
- `col_ready`, out, 1: high in state FULL.
- `distinct`, out, BINS_LOG2+1: number of distinct bins set in the write bank.

## Operation
- Storage:
  - Two bitmaps of 2^BINS_LOG2 flops each.
  - `bank_sel` selects the write bank; the other bank is the read bank.
  - Iterate counter of width `$clog2(max(SKIP,KEEP)+1)`.
- State IDLE:
  - `start` clears the write bank, `distinct` and the counter, then moves to SKIP.
  - `swap` is ignored.
- State SKIP:
  - Each `next_ready` increments the counter.
  - On the `next_ready` that brings the count to SKIP: clear the counter, move to COLLECT. That sample is discarded.
- State COLLECT:
  - Each `next_ready` sets the write-bank bit at bin(`x`) and increments the counter.
  - If that bit was previously 0, `distinct` increments in the same cycle.
  - On the KEEP-th sample: move to FULL.
- State FULL:
  - `next_ready` is ignored.
  - `swap` toggles `bank_sel` and moves to IDLE. The completed bitmap becomes readable.
  - `distinct` holds its value through the swap. It is cleared only by the next `start`.
- Ignored inputs: `start` outside IDLE; `swap` outside FULL.
- Read bank is never written. It stays stable for the entire collection of the next column.
- Reset (async, any state):
  - Both bitmaps cleared, `bank_sel`=0, state IDLE, counter 0.
  - `rd_bit`=0, `busy`=0, `col_ready`=0, `distinct`=0.

## Timing
- All state, bitmap, `distinct` and `rd_bit` updates happen on the rising `clk` edge. Reset takes effect asynchronously.
- `start` in IDLE at edge N:
  - `busy`=1 after edge N.
  - A `next_ready` in the same cycle as `start` is not counted. Counting begins with samples after edge N.
- `col_ready` rises after the edge that captures the KEEP-th recorded sample. `busy` falls at the same edge.
- `swap` in FULL at edge M:
  - `col_ready`=0 after M.
  - `rd_bit` sampled at M+1 reflects the new read bank.
  - `rd_bit` sampled at M still reflects the old read bank.
- `rd_bit`: one-cycle latency from `rd_addr`. Always sourced from the read bank selected before the edge.
- Minimum column time: 1 + SKIP + KEEP iterator periods. There is no limit on how long FULL is held. `next_ready` pulses arriving during FULL are dropped; the iterator is not back-pressured.
- Duplicate bins in COLLECT: the bit stays 1 and `distinct` is unchanged.

## Test plan
All scenarios use FRAC=8, BINS_LOG2=6, SKIP=4, KEEP=4.
- **Reset:** assert `reset` mid-cycle with no clock running → all outputs 0 immediately. Every `rd_addr` reads 0 after release.
- **Basic column:** `start`, then 4 `next_ready` pulses with `x`=0xFF (discarded), then `x`=0x40, 0x80, 0x40, 0xC0.
  - Required: `col_ready`=1 after the 4th recorded sample; `distinct`=3.
  - Then `swap`: `rd_addr` 16, 32, 48 → `rd_bit`=1. `rd_addr` 63 (bin of 0xFF), 0 and 17 → `rd_bit`=0.
- **Ignored inputs:**
  - `swap` during SKIP or COLLECT → no state change, `bank_sel` unchanged.
  - `start` during COLLECT → counter and bitmap unaffected; column still completes after exactly 4 recorded samples.
- **Coincident events:**
  - `next_ready` with `start` in IDLE → not counted; 4 further pulses are still required before COLLECT.
  - `next_ready` with `swap` in FULL → dropped; new write bank stays clear.
- **Double-buffer isolation:** after one swapped column, collect a second column with `x`=0x04. During and after collection, the read bank still returns bits 16, 32, 48 = 1 and bit 1 = 0 until the second `swap`.
- **Reset mid-COLLECT:** after 2 recorded samples, pulse `reset` → IDLE, `busy`=0, `distinct`=0, both banks clear. A fresh `start` then requires the full 4 + 4 samples.

Source files
------------

// File: rtl/logs_column_buffer.sv
// Bifurcation-diagram column collector: skips transients, bins the next KEEP
// iterates into a double-buffered one-bit-per-bin bitmap.
module logs_column_buffer #(
    parameter int FRAC      = 8,
    parameter int BINS_LOG2 = 6,
    parameter int SKIP      = 32,
    parameter int KEEP      = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [FRAC-1:0]      x,
    input  logic                 next_ready,
    input  logic                 start,
    input  logic                 swap,
    input  logic [BINS_LOG2-1:0] rd_addr,
    output logic                 rd_bit,
    output logic                 busy,
    output logic                 col_ready,
    output logic [BINS_LOG2:0]   distinct
);
    localparam int NB   = 1 << BINS_LOG2;
    localparam int MAXC = (SKIP > KEEP) ? SKIP : KEEP;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SKIP,
        S_COLLECT,
        S_FULL
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [NB-1:0]        r_bank [2];
    logic                 r_bank_sel;
    logic [CW-1:0]        r_cnt;
    logic [BINS_LOG2:0]   r_distinct;
    logic                 r_rd_bit;
    logic [CW-1:0]        w_cnt_inc;
    logic [BINS_LOG2-1:0] w_bin;
    logic                 w_hit;
    logic                 w_skip_done;
    logic                 w_keep_done;

    // Bin = top BINS_LOG2 fraction bits of x
    assign w_bin       = BINS_LOG2'(x >> (FRAC - BINS_LOG2));
    assign w_cnt_inc   = r_cnt + 1'b1;
    assign w_hit       = r_bank[r_bank_sel][w_bin];
    assign w_skip_done = (w_cnt_inc == CW'(SKIP));
    assign w_keep_done = (w_cnt_inc == CW'(KEEP));

    assign rd_bit   = r_rd_bit;
    assign distinct = r_distinct;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        busy      = 1'b0;
        col_ready = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start) w_next = S_SKIP;
            end
            S_SKIP: begin
                busy = 1'b1;
                if (next_ready && w_skip_done) w_next = S_COLLECT;
            end
            S_COLLECT: begin
                busy = 1'b1;
                if (next_ready && w_keep_done) w_next = S_FULL;
            end
            S_FULL: begin
                col_ready = 1'b1;
                if (swap) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bank[0]  <= '0;
            r_bank[1]  <= '0;
            r_bank_sel <= 1'b0;
            r_cnt      <= '0;
            r_distinct <= '0;
            r_rd_bit   <= 1'b0;
        end else begin
            // Read side always uses the bank selected before this edge
            r_rd_bit <= r_bank[~r_bank_sel][rd_addr];
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_bank[r_bank_sel] <= '0;
                        r_cnt              <= '0;
                        r_distinct         <= '0;
                    end
                end
                S_SKIP: begin
                    if (next_ready) r_cnt <= w_skip_done ? '0 : w_cnt_inc;
                end
                S_COLLECT: begin
                    if (next_ready) begin
                        r_bank[r_bank_sel][w_bin] <= 1'b1;
                        r_cnt                     <= w_cnt_inc;
                        if (!w_hit) r_distinct <= r_distinct + 1'b1;
                    end
                end
                S_FULL: begin
                    if (swap) r_bank_sel <= ~r_bank_sel;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_logs_column_buffer.sv
// Self-checking bench for logs_column_buffer against a list-based column model.
module tb_logs_column_buffer;
    localparam int FRAC = 8;
    localparam int BL   = 6;
    localparam int SK   = 4;
    localparam int KP   = 4;

    logic          clk = 1'b0;
    logic          clk_en = 1'b0;
    logic          reset = 1'b0;
    logic [FRAC-1:0] x = '0;
    logic          next_ready = 1'b0;
    logic          start = 1'b0;
    logic          swap = 1'b0;
    logic [BL-1:0] rd_addr = '0;
    logic          rd_bit;
    logic          busy;
    logic          col_ready;
    logic [BL:0]   distinct;

    int n_pass = 0;
    int n_total = 0;

    // Model: phase 0 idle, 1 skipping, 2 collecting, 3 full
    int        phase = 0;
    int        skipped = 0;
    logic [7:0] cur_q[$];
    logic [7:0] rd_q[$];
    logic [BL:0] e_dist = '0;
    logic      e_rd = 1'b0;

    logic [BL+3:0] obs;
    assign obs = {busy, col_ready, distinct, rd_bit};

    logs_column_buffer #(
        .FRAC(FRAC), .BINS_LOG2(BL), .SKIP(SK), .KEEP(KP)
    ) dut (
        .clk(clk), .reset(reset), .x(x), .next_ready(next_ready),
        .start(start), .swap(swap), .rd_addr(rd_addr), .rd_bit(rd_bit),
        .busy(busy), .col_ready(col_ready), .distinct(distinct)
    );

    always #5 if (clk_en) clk = ~clk;

    function automatic int bin_of(input logic [7:0] v);
        return int'(v) / (256 / (1 << BL));
    endfunction

    function automatic logic in_list(input logic [7:0] q[$], input int a);
        foreach (q[i]) if (bin_of(q[i]) == a) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int ucount(input logic [7:0] q[$]);
        int seen[int];
        foreach (q[i]) seen[bin_of(q[i])] = 1;
        return seen.num();
    endfunction

    function automatic logic [BL+3:0] expv();
        logic b;
        b = (phase == 1) || (phase == 2);
        return {b, phase == 3, e_dist, e_rd};
    endfunction

    task automatic model_reset();
        phase = 0;
        skipped = 0;
        cur_q.delete();
        rd_q.delete();
        e_dist = '0;
        e_rd = 1'b0;
    endtask

    task automatic step(input logic s, input logic sw, input logic nr,
                        input logic [7:0] xv, input int ra);
        @(negedge clk);
        start = s;
        swap = sw;
        next_ready = nr;
        x = xv;
        rd_addr = BL'(ra);
        @(posedge clk);
        e_rd = in_list(rd_q, ra);
        case (phase)
            0: if (s) begin
                cur_q.delete();
                skipped = 0;
                e_dist = '0;
                phase = 1;
            end
            1: if (nr) begin
                skipped++;
                if (skipped == SK) phase = 2;
            end
            2: if (nr) begin
                cur_q.push_back(xv);
                e_dist = (BL+1)'(ucount(cur_q));
                if (cur_q.size() == KP) phase = 3;
            end
            3: if (sw) begin
                rd_q = cur_q;
                phase = 0;
            end
            default: ;
        endcase
        #1;
        start = 1'b0;
        swap = 1'b0;
        next_ready = 1'b0;
    endtask

    task automatic to_idle();
        for (int i = 0; i < 20 && phase != 0; i++)
            step(0, 1, 1, 8'($urandom), 0);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #3 reset = 1'b1;
        #1;
        n_total++;
        if (obs !== '0) $display("FAIL reset_async: got %h required 0", obs);
        else n_pass++;
        #2 reset = 1'b0;
        model_reset();
        clk_en = 1'b1;
        for (int a = 0; a < (1 << BL); a++) begin
            step(0, 0, 0, 8'h00, a);
            n_total++;
            if (obs !== expv() || rd_bit !== 1'b0)
                $display("FAIL reset_read[%0d]: got %h required %h", a, obs, expv());
            else n_pass++;
        end
    endtask

    task automatic test_basic();
        logic [7:0] kv[4] = '{8'h40, 8'h80, 8'h40, 8'hC0};
        int ra[6] = '{16, 32, 48, 63, 0, 17};
        logic rq[6] = '{1, 1, 1, 0, 0, 0};
        step(1, 0, 0, 8'h00, 0);
        for (int i = 0; i < SK; i++) step(0, 0, 1, 8'hFF, 0);
        foreach (kv[i]) begin
            step(0, 0, 1, kv[i], 0);
            n_total++;
            if (obs !== expv())
                $display("FAIL basic_collect[%0d]: got %h required %h", i, obs, expv());
            else n_pass++;
        end
        n_total++;
        if (col_ready !== 1'b1 || distinct !== 7'd3)
            $display("FAIL basic_done: got col=%b dist=%0d required 1/3", col_ready, distinct);
        else n_pass++;
        step(0, 1, 0, 8'h00, 0);
        n_total++;
        if (obs !== expv())
            $display("FAIL basic_swap: got %h required %h", obs, expv());
        else n_pass++;
        foreach (ra[i]) begin
            step(0, 0, 0, 8'h00, ra[i]);
            n_total++;
            if (rd_bit !== rq[i] || obs !== expv())
                $display("FAIL basic_read[%0d]: got %b required %b", ra[i], rd_bit, rq[i]);
            else n_pass++;
        end
    endtask

    task automatic test_ignored();
        step(1, 0, 0, 8'h00, 16);
        step(0, 1, 1, 8'h20, 16);
        step(0, 1, 0, 8'h00, 16);
        n_total++;
        if (obs !== expv() || busy !== 1'b1)
            $display("FAIL ign_swap_skip: got %h required %h", obs, expv());
        else n_pass++;
        for (int i = 0; i < SK - 1; i++) step(0, 0, 1, 8'h20, 16);
        step(0, 1, 1, 8'h10, 16);
        step(1, 0, 0, 8'h00, 16);
        step(1, 1, 1, 8'h14, 32);
        n_total++;
        if (obs !== expv() || rd_bit !== 1'b1)
            $display("FAIL ign_collect: got %h required %h", obs, expv());
        else n_pass++;
        step(0, 0, 1, 8'h18, 48);
        n_total++;
        if (col_ready !== 1'b0)
            $display("FAIL ign_early_full: got %b required 0", col_ready);
        else n_pass++;
        step(0, 0, 1, 8'h1C, 48);
        n_total++;
        if (col_ready !== 1'b1 || obs !== expv())
            $display("FAIL ign_full: got %h required %h", obs, expv());
        else n_pass++;
        step(0, 1, 0, 8'h00, 0);
    endtask

    task automatic test_coincident();
        step(1, 0, 1, 8'hAA, 0);
        for (int i = 0; i < SK; i++) step(0, 0, 1, 8'hFF, 0);
        n_total++;
        if (obs !== expv() || distinct !== 7'd0)
            $display("FAIL coinc_start: got %h required %h", obs, expv());
        else n_pass++;
        step(0, 0, 1, 8'h40, 0);
        n_total++;
        if (distinct !== 7'd1)
            $display("FAIL coinc_first: got %0d required 1", distinct);
        else n_pass++;
        for (int i = 1; i < KP; i++) step(0, 0, 1, 8'h80, 0);
        step(0, 1, 1, 8'h04, 1);
        n_total++;
        if (obs !== expv() || distinct !== 7'd2)
            $display("FAIL coinc_swap: got %h required %h", obs, expv());
        else n_pass++;
        step(0, 0, 1, 8'h04, 1);
        n_total++;
        if (obs !== expv() || rd_bit !== 1'b0)
            $display("FAIL coinc_drop: got %h required %h", obs, expv());
        else n_pass++;
    endtask

    task automatic test_isolation();
        int ra[4] = '{16, 32, 48, 1};
        step(0, 0, 0, 8'h00, 0);
        step(1, 0, 0, 8'h00, 0);
        for (int i = 0; i < SK + KP; i++) begin
            step(0, 1, 1, 8'h04, ra[i % 4]);
            n_total++;
            if (obs !== expv())
                $display("FAIL iso_during[%0d]: got %h required %h", i, obs, expv());
            else n_pass++;
        end
        foreach (ra[i]) begin
            step(0, 0, 0, 8'h00, ra[i]);
            n_total++;
            if (obs !== expv())
                $display("FAIL iso_after[%0d]: got %h required %h", ra[i], obs, expv());
            else n_pass++;
        end
        step(0, 1, 0, 8'h00, 1);
        step(0, 0, 0, 8'h00, 1);
        n_total++;
        if (rd_bit !== 1'b1 || obs !== expv())
            $display("FAIL iso_swap2: got %b required 1", rd_bit);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            step(($urandom % 6) == 0, ($urandom % 5) == 0, ($urandom % 3) != 0,
                 8'($urandom), int'($urandom % 64));
            n_total++;
            if (obs !== expv())
                $display("FAIL random[%0d]: got %h required %h", i, obs, expv());
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        to_idle();
        step(1, 0, 0, 8'h00, 0);
        for (int i = 0; i < SK; i++) step(0, 0, 1, 8'hFF, 0);
        step(0, 0, 1, 8'h40, 0);
        step(0, 0, 1, 8'h80, 0);
        reset = 1'b1;
        #1;
        n_total++;
        if (obs !== '0) $display("FAIL rmid_async: got %h required 0", obs);
        else n_pass++;
        #1 reset = 1'b0;
        model_reset();
        for (int a = 0; a < (1 << BL); a += 7) begin
            step(0, 0, 0, 8'h00, a);
            n_total++;
            if (obs !== expv())
                $display("FAIL rmid_clear[%0d]: got %h required %h", a, obs, expv());
            else n_pass++;
        end
        step(1, 0, 0, 8'h00, 0);
        for (int i = 0; i < SK + KP; i++) begin
            step(0, 0, 1, 8'h40, 16);
            n_total++;
            if (obs !== expv() || col_ready !== (i == SK + KP - 1))
                $display("FAIL rmid_col[%0d]: got %h required %h", i, obs, expv());
            else n_pass++;
        end
        step(0, 1, 0, 8'h00, 16);
        step(0, 0, 0, 8'h00, 16);
        n_total++;
        if (rd_bit !== 1'b1 || obs !== expv())
            $display("FAIL rmid_read: got %b required 1", rd_bit);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ignored();
        test_coincident();
        test_isolation();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
